// File: rtl/ssa_seq_pkg.sv
// Shared definitions for the SSA RF-switch sequencer: state encodings,
// default timing constants and the permit decode helper.
package ssa_seq_pkg;

    // Encoding is visible to software through the seq_state readback register.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_RF_ON   = 3'd2,
        ST_FAULT   = 3'd3,
        ST_HOLDOFF = 3'd4,
        ST_CLEAR   = 3'd5,
        ST_LOCKOUT = 3'd6
    } seq_state_e;

    localparam logic [15:0] SETTLE_CYC_DEF  = 16'd1024;
    localparam logic [15:0] HOLDOFF_CYC_DEF = 16'd9300;
    localparam logic [15:0] CLEAR_WIDTH_DEF = 16'd4;
    localparam logic [1:0]  MAX_RETRY_DEF   = 2'd3;

    // Permit is good only when no fault is latched and the SSA is presently enabled.
    function automatic logic permit_ok(input logic [1:0] prmt);
        return (prmt == 2'b11);
    endfunction

endpackage

// File: rtl/ssa_rf_sequencer_seq_timer.sv
// Shared dwell timer for the sequencer: 16-bit up-counter with synchronous
// clear, count enable and saturation; done flags the last cycle of a dwell.
module seq_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] limit,
    output logic        done
);

    logic [15:0] count_r;

    // Count up from the last clear, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 16'd0;
        end else if (clr) begin
            count_r <= 16'd0;
        end else if (en && (count_r != 16'hFFFF)) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == (limit - 16'd1));

endmodule

// File: rtl/ssa_rf_sequencer.sv
// Per-cavity SSA turn-on / RF-switch sequencer. Waits for a settled permit,
// closes the RF switch, and on a fault runs a bounded holdoff/clear/retry
// recovery before locking out until an operator fault reset.
module ssa_rf_sequencer
    import ssa_seq_pkg::*;
#(
    parameter logic [15:0] SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter logic [15:0] HOLDOFF_CYC = HOLDOFF_CYC_DEF,
    parameter logic [15:0] CLEAR_WIDTH = CLEAR_WIDTH_DEF,
    parameter logic [1:0]  MAX_RETRY   = MAX_RETRY_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rf_on_req,
    input  logic       fault_reset,
    input  logic [1:0] ssa_prmt,
    input  logic       ssa_prmt_pulse,
    output logic       ssa_clear,
    output logic       rf_sw_en,
    output logic       fault_strobe,
    output logic       lockout,
    output logic [1:0] retry_cnt,
    output logic [2:0] seq_state
);

    seq_state_e  state_r;
    seq_state_e  next_state_s;
    logic [1:0]  retry_cnt_r;
    logic [1:0]  retry_nxt_s;
    logic        ssa_clear_r;
    logic        fault_strobe_r;
    logic        lockout_r;
    logic        prmt_ok_s;
    logic        fault_s;
    logic        timer_clr_s;
    logic        timer_done_s;
    logic [15:0] timer_limit_s;

    assign prmt_ok_s = permit_ok(ssa_prmt);
    assign fault_s   = ssa_prmt_pulse | ~ssa_prmt[1];

    // Transition rules; a fault takes priority over a request drop or fault reset.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rf_on_req && prmt_ok_s) begin
                    next_state_s = ST_SETTLE;
                end else if (rf_on_req && !ssa_prmt[1]) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!rf_on_req) begin
                    next_state_s = ST_IDLE;
                end else if (prmt_ok_s && timer_done_s) begin
                    next_state_s = ST_RF_ON;
                end else begin
                    next_state_s = ST_SETTLE;
                end
            end
            ST_RF_ON: begin
                if (fault_s) begin
                    next_state_s = ST_FAULT;
                end else if (!rf_on_req) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RF_ON;
                end
            end
            ST_FAULT: begin
                if (retry_cnt_r < MAX_RETRY) begin
                    next_state_s = ST_HOLDOFF;
                end else begin
                    next_state_s = ST_LOCKOUT;
                end
            end
            ST_HOLDOFF: begin
                if (timer_done_s) begin
                    next_state_s = ST_CLEAR;
                end else begin
                    next_state_s = ST_HOLDOFF;
                end
            end
            ST_CLEAR: begin
                if (timer_done_s && rf_on_req) begin
                    next_state_s = ST_SETTLE;
                end else if (timer_done_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_CLEAR;
                end
            end
            ST_LOCKOUT: begin
                if (fault_reset) begin
                    next_state_s = ST_CLEAR;
                end else begin
                    next_state_s = ST_LOCKOUT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Retry accounting: bump on every fault, forget history on a clean stop or operator reset.
    always_comb begin
        retry_nxt_s = retry_cnt_r;
        if (state_r == ST_FAULT) begin
            if (retry_cnt_r < MAX_RETRY) begin
                retry_nxt_s = retry_cnt_r + 2'd1;
            end else begin
                retry_nxt_s = retry_cnt_r;
            end
        end else if ((next_state_s == ST_IDLE) &&
                     ((state_r == ST_RF_ON) || (state_r == ST_CLEAR))) begin
            retry_nxt_s = 2'd0;
        end else if (fault_reset && (next_state_s != ST_FAULT)) begin
            retry_nxt_s = 2'd0;
        end else begin
            retry_nxt_s = retry_cnt_r;
        end
    end

    // Select the dwell length for the state the timer is currently measuring.
    always_comb begin
        timer_limit_s = 16'd0;
        case (state_r)
            ST_SETTLE:  timer_limit_s = SETTLE_CYC;
            ST_HOLDOFF: timer_limit_s = HOLDOFF_CYC;
            ST_CLEAR:   timer_limit_s = CLEAR_WIDTH;
            default:    timer_limit_s = 16'd0;
        endcase
    end

    // Restart the dwell on every state change, and in SETTLE on any imperfect permit.
    assign timer_clr_s = (next_state_s != state_r) ||
                         ((state_r == ST_SETTLE) && !prmt_ok_s);

    seq_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr_s),
        .en    (1'b1),
        .limit (timer_limit_s),
        .done  (timer_done_s)
    );

    // State, retry counter and registered outputs decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            retry_cnt_r    <= 2'd0;
            ssa_clear_r    <= 1'b0;
            fault_strobe_r <= 1'b0;
            lockout_r      <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            retry_cnt_r    <= retry_nxt_s;
            ssa_clear_r    <= (next_state_s == ST_CLEAR);
            fault_strobe_r <= (next_state_s == ST_FAULT);
            lockout_r      <= (next_state_s == ST_LOCKOUT);
        end
    end

    // The switch gate is combinational so a fault opens it in the same cycle.
    assign rf_sw_en     = (state_r == ST_RF_ON) & ssa_prmt[1] & ~ssa_prmt_pulse;
    assign ssa_clear    = ssa_clear_r;
    assign fault_strobe = fault_strobe_r;
    assign lockout      = lockout_r;
    assign retry_cnt    = retry_cnt_r;
    assign seq_state    = state_r;

endmodule
